// File: rtl/des_pkg.sv
// Shared types for the DES output byte serializer.
// Block/byte widths, state encoding and byte-lane helpers.
package des_pkg;

  localparam int DES_BLOCK_W = 64;
  localparam int DES_BYTE_W  = 8;
  localparam int DES_BYTES   = DES_BLOCK_W / DES_BYTE_W;
  localparam int DES_CNT_W   = $clog2(DES_BYTES);

  typedef logic [DES_BLOCK_W-1:0] des_block_t;
  typedef logic [DES_BYTE_W-1:0]  des_byte_t;

  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_e;

  function automatic des_byte_t pick_byte(
    input des_block_t b,
    input bit         msb
  );
    return msb ? b[DES_BLOCK_W-1 -: DES_BYTE_W]
               : b[DES_BYTE_W-1:0];
  endfunction

  function automatic des_block_t shift_byte(
    input des_block_t b,
    input bit         msb
  );
    return msb
      ? {b[DES_BLOCK_W-DES_BYTE_W-1:0], {DES_BYTE_W{1'b0}}}
      : {{DES_BYTE_W{1'b0}}, b[DES_BLOCK_W-1:DES_BYTE_W]};
  endfunction

endpackage

// File: rtl/des_block_fifo.sv
// Circular DEPTH x 64 block buffer with occupancy counter.
// A push while full is taken only when a pop happens on the same edge.
module des_block_fifo
  import des_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         push,
  input  des_block_t                   push_data,
  input  logic                         pop,
  output des_block_t                   pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  des_block_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign count    = cnt_q;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= ptr_nxt(wr_ptr);
      if (do_pop)
        rd_ptr <= ptr_nxt(rd_ptr);
      if (do_push && !do_pop)
        cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage needs no reset; only pointers/occupancy define validity.
  always_ff @(posedge clk_in) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/des_out_serializer.sv
// Buffers 64-bit DES blocks and streams them out byte-wise
// over valid/ready, flagging the final byte of each block.
module des_out_serializer
  import des_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [63:0] data_in,
  input  logic        data_in_valid,
  output logic [7:0]  byte_out,
  output logic        byte_out_valid,
  input  logic        byte_out_ready,
  output logic        byte_out_last,
  output logic        busy,
  output logic        overflow
);

  localparam int CNT_W = $clog2(DEPTH+1);

  ser_state_e           state_q;
  ser_state_e           state_d;
  des_block_t           shift_q;
  logic [DES_CNT_W-1:0] cnt_q;
  logic                 ovf_q;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  des_block_t           fifo_data;

  logic                 hs;
  logic                 at_last;
  logic                 dropped;

  des_block_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (data_in_valid),
    .push_data (data_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign hs      = byte_out_valid && byte_out_ready;
  assign at_last = (cnt_q == DES_CNT_W'(DES_BYTES-1));
  // Full with no same-edge pop means the incoming block is lost.
  assign dropped = data_in_valid && fifo_full && !fifo_pop;

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      SER_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = SER_SEND;
        end
      end
      SER_SEND: begin
        if (hs && at_last) begin
          if (!fifo_empty)
            fifo_pop = 1'b1;
          else
            state_d = SER_IDLE;
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      state_q <= SER_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shift_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (dropped)
        ovf_q <= 1'b1;
      if (fifo_pop) begin
        shift_q <= fifo_data;
        cnt_q   <= '0;
      end else if (hs) begin
        shift_q <= at_last ? '0 : shift_byte(shift_q, MSB_FIRST);
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

  assign byte_out       = pick_byte(shift_q, MSB_FIRST);
  assign byte_out_valid = (state_q == SER_SEND);
  assign byte_out_last  = byte_out_valid && at_last;
  assign busy           = (fifo_count != '0) || byte_out_valid;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_des_out_serializer.sv
// Directed bench for des_out_serializer: MSB-first and
// LSB-first instances share stimulus; a negedge monitor logs bytes.
module tb_des_out_serializer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [63:0] data_in;
  logic        data_in_valid;
  logic        byte_out_ready;

  logic [7:0]  byte_out;
  logic        byte_out_valid;
  logic        byte_out_last;
  logic        busy;
  logic        overflow;

  logic [7:0]  l_byte;
  logic        l_valid;
  logic        l_last;
  logic        l_busy;
  logic        l_ovf;

  des_out_serializer #(.DEPTH(2), .MSB_FIRST(1'b1)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .byte_out       (byte_out),
    .byte_out_valid (byte_out_valid),
    .byte_out_ready (byte_out_ready),
    .byte_out_last  (byte_out_last),
    .busy           (busy),
    .overflow       (overflow)
  );

  des_out_serializer #(.DEPTH(2), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .byte_out       (l_byte),
    .byte_out_valid (l_valid),
    .byte_out_ready (byte_out_ready),
    .byte_out_last  (l_last),
    .busy           (l_busy),
    .overflow       (l_ovf)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit bp_mode = 1'b0;
  int bp_k = 0;
  int stall_err = 0;

  logic [7:0] mq[$];
  logic [7:0] lq[$];
  bit         lastq[$];
  int         cycq[$];

  bit         pv, pr, pl;
  logic [7:0] pb;

  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (pv && !pr) begin
        if (byte_out_valid !== 1'b1 || byte_out !== pb ||
            byte_out_last !== pl)
          stall_err++;
      end
      if (byte_out_valid && byte_out_ready) begin
        mq.push_back(byte_out);
        lastq.push_back(byte_out_last);
        cycq.push_back(cyc);
      end
      if (l_valid && byte_out_ready)
        lq.push_back(l_byte);
    end
    pv = !rst_in && byte_out_valid;
    pr = byte_out_ready;
    pb = byte_out;
    pl = byte_out_last;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    if (bp_mode) begin
      byte_out_ready = (bp_k % 4 == 0) || (bp_k % 4 == 3);
      bp_k++;
    end
  endtask

  task automatic pulse(input logic [63:0] blk);
    data_in       = blk;
    data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0;
    data_in       = '0;
  endtask

  task automatic clear_q();
    mq.delete();
    lq.delete();
    lastq.delete();
    cycq.delete();
  endtask

  task automatic reset_dut();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    step();
  endtask

  task automatic wait_bytes(input string tag, input int n,
                            input int budget);
    int k = 0;
    while (mq.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, mq.size(), n);
  endtask

  function automatic logic [7:0] exp_byte(input logic [63:0] b,
                                          input int i,
                                          input bit msb);
    return msb ? b[63-8*i -: 8] : b[8*i +: 8];
  endfunction

  task automatic check_stream(input string tag,
                              input logic [63:0] blks[4],
                              input int nblk, input bit contig);
    int eb = 0;
    int el = 0;
    int ec = 0;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 8; i++) begin
        int idx = b * 8 + i;
        if (mq[idx] !== exp_byte(blks[b], i, 1'b1)) eb++;
        if (lastq[idx] !== (i == 7)) el++;
        if (contig && cycq[idx] - cycq[0] != idx) ec++;
      end
    end
    chk({tag, "_bytes"}, eb, 0);
    chk({tag, "_last"}, el, 0);
    if (contig) chk({tag, "_gapless"}, ec, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] blks[4];
    int el;

    rst_in         = 1'b1;
    data_in        = '0;
    data_in_valid  = 1'b0;
    byte_out_ready = 1'b1;
    #2;
    chk("reset_outs",
        {byte_out, byte_out_valid, byte_out_last, busy, overflow},
        '0);
    step();
    rst_in = 1'b0;
    step();

    // single block, both byte orders
    clear_q();
    pulse(64'h85E813540F0AB405);
    chk("lat_not_yet", byte_out_valid, 1'b0);
    step();
    chk("lat_valid", byte_out_valid, 1'b1);
    chk("lat_first_msb", byte_out, 8'h85);
    chk("lat_first_lsb", l_byte, 8'h05);
    wait_bytes("single_cnt", 8, 40);
    blks[0] = 64'h85E813540F0AB405;
    check_stream("single", blks, 1, 1'b1);
    chk("single_busy_low", {busy, l_busy}, 2'b00);
    el = 0;
    for (int i = 0; i < 8; i++)
      if (lq[i] !== exp_byte(blks[0], i, 1'b0)) el++;
    chk("lsb_order", el, 0);

    // back-to-back blocks
    clear_q();
    pulse(64'h0123456789ABCDEF);
    pulse(64'hFEDCBA9876543210);
    wait_bytes("b2b_cnt", 16, 60);
    blks[0] = 64'h0123456789ABCDEF;
    blks[1] = 64'hFEDCBA9876543210;
    check_stream("b2b", blks, 2, 1'b1);

    // backpressure 1,0,0,1
    repeat (4) step();
    clear_q();
    stall_err = 0;
    bp_mode   = 1'b1;
    bp_k      = 0;
    pulse(64'h0123456789ABCDEF);
    wait_bytes("bp_cnt", 8, 80);
    bp_mode        = 1'b0;
    byte_out_ready = 1'b1;
    blks[0] = 64'h0123456789ABCDEF;
    check_stream("bp", blks, 1, 1'b0);
    chk("bp_stall_stable", stall_err, 0);

    // overflow with ready low
    repeat (4) step();
    clear_q();
    byte_out_ready = 1'b0;
    pulse(64'h85E813540F0AB405);
    pulse(64'h0123456789ABCDEF);
    pulse(64'hFEDCBA9876543210);
    chk("ovf_before", overflow, 1'b0);
    pulse(64'h1111111111111111);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_stall_hold", {byte_out_valid, byte_out}, {1'b1, 8'h85});
    byte_out_ready = 1'b1;
    wait_bytes("ovf_cnt", 24, 100);
    repeat (10) step();
    chk("ovf_no_extra", mq.size(), 24);
    blks[0] = 64'h85E813540F0AB405;
    blks[1] = 64'h0123456789ABCDEF;
    blks[2] = 64'hFEDCBA9876543210;
    check_stream("ovf", blks, 3, 1'b1);
    chk("ovf_sticky", overflow, 1'b1);
    chk("ovf_stall_err", stall_err, 0);

    // push on full coinciding with last-byte pop
    reset_dut();
    chk("rst_clears_ovf", overflow, 1'b0);
    clear_q();
    pulse(64'h85E813540F0AB405);
    pulse(64'h0123456789ABCDEF);
    pulse(64'hFEDCBA9876543210);
    repeat (6) step();
    chk("pof_last_align", byte_out_last, 1'b1);
    pulse(64'h0F1E2D3C4B5A6978);
    wait_bytes("pof_cnt", 32, 120);
    chk("pof_no_ovf", overflow, 1'b0);
    blks[3] = 64'h0F1E2D3C4B5A6978;
    check_stream("pof", blks, 4, 1'b1);

    // asynchronous reset mid-block
    repeat (4) step();
    clear_q();
    pulse(64'h85E813540F0AB405);
    wait_bytes("mid_cnt", 3, 20);
    rst_in = 1'b1;
    #1;
    chk("mid_rst_outs",
        {byte_out, byte_out_valid, byte_out_last, busy,
         l_byte, l_valid, l_busy},
        '0);
    #2;
    rst_in = 1'b0;
    clear_q();
    repeat (10) step();
    chk("mid_no_partial", mq.size() + lq.size(), 0);
    pulse(64'hFEDCBA9876543210);
    wait_bytes("mid_new_cnt", 8, 40);
    blks[0] = 64'hFEDCBA9876543210;
    check_stream("mid_new", blks, 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_out_serializer.md
Name: des_out_serializer

Overview:
- Output stage directly downstream of the DES inverse-initial-permutation stage.
- Captures each 64-bit ciphertext block that stage delivers. The delivery is a single-cycle data_in_valid pulse with no backpressure.
- Buffers blocks in a small FIFO and emits them as a byte stream over a valid/ready handshake toward the host/UART/AXI-stream side, flagging the last byte of each block.

Parameters:
- DEPTH, 2, number of 64-bit blocks buffered (>=1). The block being shifted out is held in the shifter and is not counted.
- MSB_FIRST, 1, 1: byte order [63:56] first; 0: byte order [7:0] first.

Ports:
- clk_in  input  1  clock; all logic on its rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- data_in  input  64  ciphertext block from the IP^-1 stage.
- data_in_valid  input  1  one-cycle strobe; data_in is valid this cycle.
- byte_out  output  8  current output byte.
- byte_out_valid  output  1  byte_out is valid.
- byte_out_ready  input  1  consumer accepts the byte when it and byte_out_valid are both high at an edge.
- byte_out_last  output  1  high with the 8th byte of each block.
- busy  output  1  high when the FIFO is non-empty or the shifter is loaded.
- overflow  output  1  sticky; set when a block is dropped.

Behaviour:
- Reset (asynchronous, rst_in=1): all outputs 0. FIFO pointers, occupancy, byte counter, shifter and FSM are cleared. Reset mid-block discards all buffered data with no partial output afterwards.
- FIFO: circular buffer of DEPTH x 64, with a write pointer, read pointer and occupancy counter (width clog2(DEPTH+1)). Pointers wrap DEPTH-1 -> 0.
- Write: data_in_valid at edge t writes data_in when occupancy<DEPTH, or when occupancy==DEPTH and a pop occurs at the same edge.
- Drop: otherwise the block is dropped, the FIFO is unchanged and overflow is set to 1. overflow stays 1 until reset.
- FSM states:
  - IDLE: shifter empty, byte_out_valid=0. If FIFO non-empty, pop into the shifter, counter=0, go to SEND.
  - SEND: byte_out_valid=1.
    - On a handshake with counter<7: shift 8 bits toward the output and increment the counter.
    - On a handshake with counter==7: if FIFO non-empty, pop the next block into the shifter the same edge with counter=0 and stay in SEND (no bubble). Otherwise go to IDLE.
    - Without a handshake: byte_out and byte_out_last hold stable.
- Latency: a block written at edge t into an empty FIFO with the shifter idle is loaded at edge t+1. Its first byte is visible after edge t+1, i.e. 2 cycles from the data_in_valid edge. Throughput is 1 byte/cycle with ready held high.
- byte_out_last = (state==SEND && counter==7).
- Simultaneous push and pop at the same edge: both happen and occupancy is unchanged.
- busy = (occupancy!=0) || (state==SEND).
- Byte selection: MSB_FIRST=1 shifts left and byte_out=shifter[63:56]. MSB_FIRST=0 shifts right and byte_out=shifter[7:0].

Decomposition:
- des_pkg holds:
  - DES_BLOCK_W=64 and DES_BYTE_W=8;
  - typedef des_block_t (logic [63:0]);
  - enum ser_state_e {SER_IDLE, SER_SEND}.
- One natural sub-module: des_block_fifo. It is a parameterised DEPTH x 64 FIFO with push, pop, full, empty and count. It must support push on full when popping in the same cycle.
- The FSM, shifter and counter remain in the top level.

Test Plan:
- Single block, ready=1: data_in=64'h85E813540F0AB405 pulse at cycle 0 -> first byte visible after edge 1. Bytes 85,E8,13,54,0F,0A,B4,05 on 8 consecutive cycles, last=1 only on 05. busy drops after the final transfer.
- Back-to-back, ready=1: blocks 64'h0123456789ABCDEF and 64'hFEDCBA9876543210 on consecutive cycles -> 16 contiguous bytes with no gap and last on bytes 8 and 16.
- Backpressure: ready toggles 1,0,0,1 repeatedly -> byte_out, valid and last are stable during stalls. Byte order is unchanged and no byte is duplicated or skipped.
- Overflow: DEPTH=2, ready=0, 4 block pulses -> block 1 is in the shifter, blocks 2-3 are in the FIFO, block 4 is dropped and overflow=1. After releasing ready, exactly 24 bytes come out with blocks 1-3 in order, and overflow stays 1.
- Push on full with pop: FIFO full, and a new pulse coincides with the last-byte handshake -> the block is accepted and overflow stays 0.
- Reset mid-block: assert rst_in after 3 bytes of 64'h85E813540F0AB405 -> outputs go to 0 immediately (asynchronous). After release, no bytes come out until a new block; a new block is emitted complete and in order.
- MSB_FIRST=0: 64'h85E813540F0AB405 -> bytes 05,B4,0A,0F,54,13,E8,85.
